// File: rtl/ctrl_pkg.sv
// Shared constants for the multi-cycle core: FSM state encoding, PC/writeback
// select codes, and the ALU/opcode constants used by the decoder.
package ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_REL    = 2'd1,
        PC_RS1    = 2'd2
    } pc_src_e;

    typedef enum logic {
        WB_ALU = 1'b0,
        WB_MEM = 1'b1
    } wb_sel_e;

    // RV32I major opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLT  = 4'd2;
    localparam logic [3:0] ALU_SLTU = 4'd3;
    localparam logic [3:0] ALU_AND  = 4'd4;
    localparam logic [3:0] ALU_OR   = 4'd5;
    localparam logic [3:0] ALU_XOR  = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

endpackage

// File: rtl/ctrl_fsm.sv
// Multi-cycle core control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT sequencing with
// memory handshakes, datapath enables and a retired-instruction counter.
module ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int WORD  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             dec_regwrite,
    input  logic             dec_memtoreg,
    input  logic             dec_memwrite,
    input  logic             dec_branch,
    input  logic             dec_jump,
    input  logic             dec_jumpsrc,
    input  logic             dec_hlt,
    input  logic             inv_br,
    input  logic             alu_lsb,
    output logic             imem_req,
    output logic             ir_we,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             rf_we,
    output logic             wb_sel,
    output logic             pc_we,
    output logic [1:0]       pc_src,
    output logic             halted,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    if (WORD < 8) begin : g_word_check
        $error("ctrl_fsm: WORD must be at least 8 bits");
    end

    state_e           state_q, state_d;
    logic             run_q;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             mem_op;
    logic             taken;

    assign mem_op = dec_memtoreg | dec_memwrite;
    assign taken  = alu_lsb ^ inv_br;

    // run_q keeps every output quiet while reset is held and until the first
    // edge after release, so a request always starts cleanly in FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            run_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            run_q     <= 1'b1;
            retired_q <= retired_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (run_q) begin
            unique case (state_q)
                ST_FETCH:  if (imem_ready) state_d = ST_DECODE;
                ST_DECODE: state_d = dec_hlt ? ST_HALT : ST_EXEC;
                ST_EXEC: begin
                    if (!dec_branch && !dec_jump && mem_op) state_d = ST_MEM;
                    else                                    state_d = ST_FETCH;
                end
                ST_MEM: begin
                    if (dmem_ready) state_d = dec_memwrite ? ST_FETCH : ST_WB;
                end
                ST_WB:     state_d = ST_FETCH;
                ST_HALT:   state_d = ST_HALT;
                default:   state_d = ST_FETCH;
            endcase
        end
    end

    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        wb_sel   = WB_ALU;
        pc_we    = 1'b0;
        pc_src   = PC_PLUS4;
        halted   = 1'b0;
        if (run_q) begin
            unique case (state_q)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_we    = imem_ready;
                end
                ST_DECODE: ;
                ST_EXEC: begin
                    if (dec_branch) begin
                        pc_we  = 1'b1;
                        pc_src = taken ? PC_REL : PC_PLUS4;
                    end else if (dec_jump) begin
                        rf_we  = 1'b1;
                        pc_we  = 1'b1;
                        pc_src = dec_jumpsrc ? PC_RS1 : PC_REL;
                    end else if (!mem_op) begin
                        rf_we  = dec_regwrite;
                        pc_we  = 1'b1;
                    end
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = dec_memwrite;
                    pc_we    = dmem_ready & dec_memwrite;
                end
                ST_WB: begin
                    rf_we  = 1'b1;
                    wb_sel = WB_MEM;
                    pc_we  = 1'b1;
                end
                ST_HALT:  halted = 1'b1;
                default: ;
            endcase
        end
    end

    assign retired_d = retired_q + CNT_W'(pc_we);
    assign retired   = retired_q;
    assign state     = state_q;

endmodule

// File: tb/tb_ctrl_fsm.sv
// Self-checking bench for ctrl_fsm: directed scenarios plus a randomized
// instruction stream checked against per-instruction timing/enable rules.
module tb_ctrl_fsm;
    import ctrl_pkg::*;

    localparam int CNT_W = 4;
    localparam int CNT_MOD = 1 << CNT_W;
    localparam int C_ALU = 0, C_BR = 1, C_JMP = 2, C_LD = 3, C_ST = 4;

    logic clk, rst_n, imem_ready, dmem_ready;
    logic dec_regwrite, dec_memtoreg, dec_memwrite, dec_branch, dec_jump, dec_jumpsrc, dec_hlt;
    logic inv_br, alu_lsb;
    logic imem_req, ir_we, dmem_req, dmem_we, rf_we, wb_sel, pc_we, halted;
    logic [1:0] pc_src;
    logic [2:0] state;
    logic [CNT_W-1:0] retired;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;

    int r_cycles, r_ir, r_rf_alu, r_rf_mem, r_dreq, r_dwe_hi, r_dwe_lo;
    int r_pc_src;
    int r_retired;

    ctrl_fsm #(.WORD(32), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .dec_regwrite(dec_regwrite), .dec_memtoreg(dec_memtoreg), .dec_memwrite(dec_memwrite),
        .dec_branch(dec_branch), .dec_jump(dec_jump), .dec_jumpsrc(dec_jumpsrc), .dec_hlt(dec_hlt),
        .inv_br(inv_br), .alu_lsb(alu_lsb),
        .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .rf_we(rf_we), .wb_sel(wb_sel), .pc_we(pc_we), .pc_src(pc_src),
        .halted(halted), .state(state), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Runs one instruction from FETCH until its pc_we cycle, answering the
    // memory handshakes after the requested number of wait cycles and
    // toggling the ready lines randomly whenever no request is pending.
    task automatic exec_instr(input int cls, input bit rw, input bit lsb, input bit inv,
                              input bit jsrc, input int fw, input int mw);
        int seen_i, seen_d;
        bit done;
        dec_regwrite = rw;
        dec_memtoreg = (cls == C_LD);
        dec_memwrite = (cls == C_ST);
        dec_branch   = (cls == C_BR);
        dec_jump     = (cls == C_JMP);
        dec_jumpsrc  = jsrc;
        dec_hlt      = 1'b0;
        alu_lsb      = lsb;
        inv_br       = inv;
        r_cycles = 0; r_ir = 0; r_rf_alu = 0; r_rf_mem = 0;
        r_dreq = 0; r_dwe_hi = 0; r_dwe_lo = 0; r_pc_src = -1;
        seen_i = 0; seen_d = 0; done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk); #1;
            if (imem_req) begin imem_ready = (seen_i == fw); seen_i++; end
            else imem_ready = 1'($urandom_range(1));
            if (dmem_req) begin dmem_ready = (seen_d == mw); seen_d++; end
            else dmem_ready = 1'($urandom_range(1));
            #1;
            r_cycles++;
            if (ir_we) r_ir++;
            if (rf_we && !wb_sel) r_rf_alu++;
            if (rf_we && wb_sel) r_rf_mem++;
            if (dmem_req) begin
                r_dreq++;
                if (dmem_we) r_dwe_hi++; else r_dwe_lo++;
            end
            if (pc_we) begin r_pc_src = int'(pc_src); done = 1'b1; end
        end
        @(negedge clk);
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #2;
        r_retired = int'(retired);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        imem_ready = 1'b1; dmem_ready = 1'b1;
        dec_regwrite = 1'b1; dec_memtoreg = 1'b0; dec_memwrite = 1'b0; dec_branch = 1'b0;
        dec_jump = 1'b0; dec_jumpsrc = 1'b0; dec_hlt = 1'b0; inv_br = 1'b0; alu_lsb = 1'b0;
        #3;
        n_tests++;
        if ({imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, halted} !== 7'b0) begin
            n_fail++; $display("[TB] FAIL reset_outputs: got %b want 0000000",
                {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, halted});
        end
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        n_tests++;
        if ({imem_req, ir_we, pc_we} !== 3'b0 || retired !== '0 || state !== ST_FETCH) begin
            n_fail++; $display("[TB] FAIL reset_hold: got req/ir/pc=%b retired=%0d state=%0d want 000/0/%0d",
                {imem_req, ir_we, pc_we}, retired, state, ST_FETCH);
        end
        rst_n = 1'b1;
        imem_ready = 1'b0; dmem_ready = 1'b0;
        @(negedge clk); #1;
        n_tests++;
        if (imem_req !== 1'b1 || state !== ST_FETCH || retired !== '0) begin
            n_fail++; $display("[TB] FAIL reset_release: got imem_req=%b state=%0d retired=%0d want 1/%0d/0",
                imem_req, state, retired, ST_FETCH);
        end
        exp_cnt = 0;
    endtask

    task automatic test_alu();
        exec_instr(C_ALU, 1'b1, 1'b0, 1'b0, 1'b0, 2, 0);
        exp_cnt++;
        n_tests++;
        if (r_cycles !== 5 || r_ir !== 1) begin
            n_fail++; $display("[TB] FAIL alu_timing: got cycles=%0d ir_we=%0d want 5/1", r_cycles, r_ir);
        end
        n_tests++;
        if (r_rf_alu !== 1 || r_rf_mem !== 0 || r_pc_src !== 0) begin
            n_fail++; $display("[TB] FAIL alu_enables: got rf_alu=%0d rf_mem=%0d pc_src=%0d want 1/0/0",
                r_rf_alu, r_rf_mem, r_pc_src);
        end
        n_tests++;
        if (r_retired !== exp_cnt % CNT_MOD) begin
            n_fail++; $display("[TB] FAIL alu_retired: got %0d want %0d", r_retired, exp_cnt % CNT_MOD);
        end
    endtask

    task automatic test_branch();
        exec_instr(C_BR, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
        exp_cnt++;
        n_tests++;
        if (r_pc_src !== 1 || r_rf_alu + r_rf_mem !== 0 || r_cycles !== 3) begin
            n_fail++; $display("[TB] FAIL branch_taken: got pc_src=%0d rf_we=%0d cycles=%0d want 1/0/3",
                r_pc_src, r_rf_alu + r_rf_mem, r_cycles);
        end
        exec_instr(C_BR, 1'b1, 1'b1, 1'b1, 1'b0, 1, 0);
        exp_cnt++;
        n_tests++;
        if (r_pc_src !== 0 || r_rf_alu + r_rf_mem !== 0 || r_cycles !== 4) begin
            n_fail++; $display("[TB] FAIL branch_not_taken: got pc_src=%0d rf_we=%0d cycles=%0d want 0/0/4",
                r_pc_src, r_rf_alu + r_rf_mem, r_cycles);
        end
    endtask

    task automatic test_load();
        exec_instr(C_LD, 1'b1, 1'b0, 1'b0, 1'b0, 0, 3);
        exp_cnt++;
        n_tests++;
        if (r_dreq !== 4 || r_dwe_hi !== 0) begin
            n_fail++; $display("[TB] FAIL load_dmem: got dmem_req cycles=%0d dmem_we cycles=%0d want 4/0",
                r_dreq, r_dwe_hi);
        end
        n_tests++;
        if (r_rf_alu !== 0 || r_rf_mem !== 1 || r_pc_src !== 0 || r_cycles !== 8) begin
            n_fail++; $display("[TB] FAIL load_wb: got rf_alu=%0d rf_mem=%0d pc_src=%0d cycles=%0d want 0/1/0/8",
                r_rf_alu, r_rf_mem, r_pc_src, r_cycles);
        end
    endtask

    task automatic test_store_jalr();
        int start;
        start = exp_cnt;
        exec_instr(C_ST, 1'b0, 1'b0, 1'b0, 1'b0, 1, 2);
        exp_cnt++;
        n_tests++;
        if (r_dwe_lo !== 0 || r_dreq !== 3 || r_pc_src !== 0 || r_rf_alu + r_rf_mem !== 0 || r_cycles !== 7) begin
            n_fail++; $display("[TB] FAIL store: got dwe_lo=%0d dreq=%0d pc_src=%0d rf=%0d cycles=%0d want 0/3/0/0/7",
                r_dwe_lo, r_dreq, r_pc_src, r_rf_alu + r_rf_mem, r_cycles);
        end
        exec_instr(C_JMP, 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
        exp_cnt++;
        n_tests++;
        if (r_pc_src !== 2 || r_rf_alu !== 1 || r_cycles !== 3) begin
            n_fail++; $display("[TB] FAIL jalr: got pc_src=%0d rf_alu=%0d cycles=%0d want 2/1/3",
                r_pc_src, r_rf_alu, r_cycles);
        end
        n_tests++;
        if (r_retired !== (start + 2) % CNT_MOD) begin
            n_fail++; $display("[TB] FAIL store_jalr_retired: got %0d want %0d", r_retired, (start + 2) % CNT_MOD);
        end
    endtask

    task automatic test_random();
        int cls, fw, mw, e_cyc, e_rf_alu, e_src, e_dreq;
        bit rw, lsb, inv, jsrc;
        for (int k = 0; k < 40; k++) begin
            cls = $urandom_range(4); fw = $urandom_range(3); mw = $urandom_range(3);
            rw = 1'($urandom_range(1)); lsb = 1'($urandom_range(1));
            inv = 1'($urandom_range(1)); jsrc = 1'($urandom_range(1));
            exec_instr(cls, rw, lsb, inv, jsrc, fw, mw);
            exp_cnt++;
            e_cyc    = fw + 3 + (cls == C_LD ? mw + 2 : (cls == C_ST ? mw + 1 : 0));
            e_rf_alu = (cls == C_ALU) ? int'(rw) : (cls == C_JMP ? 1 : 0);
            e_src    = (cls == C_BR) ? ((lsb != inv) ? 1 : 0) : (cls == C_JMP ? (jsrc ? 2 : 1) : 0);
            e_dreq   = (cls == C_LD || cls == C_ST) ? mw + 1 : 0;
            n_tests++;
            if (r_cycles !== e_cyc || r_ir !== 1) begin
                n_fail++; $display("[TB] FAIL rand%0d_timing cls=%0d: got cycles=%0d ir=%0d want %0d/1",
                    k, cls, r_cycles, r_ir, e_cyc);
            end
            n_tests++;
            if (r_rf_alu !== e_rf_alu || r_rf_mem !== int'(cls == C_LD) || r_pc_src !== e_src) begin
                n_fail++; $display("[TB] FAIL rand%0d_enables cls=%0d: got rf_alu=%0d rf_mem=%0d pc_src=%0d want %0d/%0d/%0d",
                    k, cls, r_rf_alu, r_rf_mem, r_pc_src, e_rf_alu, int'(cls == C_LD), e_src);
            end
            n_tests++;
            if (r_dreq !== e_dreq || (cls == C_ST ? r_dwe_lo : r_dwe_hi) !== 0) begin
                n_fail++; $display("[TB] FAIL rand%0d_dmem cls=%0d: got dreq=%0d dwe_hi=%0d dwe_lo=%0d want dreq=%0d",
                    k, cls, r_dreq, r_dwe_hi, r_dwe_lo, e_dreq);
            end
            n_tests++;
            if (r_retired !== exp_cnt % CNT_MOD) begin
                n_fail++; $display("[TB] FAIL rand%0d_retired: got %0d want %0d", k, r_retired, exp_cnt % CNT_MOD);
            end
        end
    endtask

    task automatic test_reset_mid_mem();
        int seen_mem;
        seen_mem = 0;
        dec_memtoreg = 1'b1; dec_memwrite = 1'b0; dec_branch = 1'b0; dec_jump = 1'b0; dec_hlt = 1'b0;
        for (int c = 0; c < 30 && seen_mem < 2; c++) begin
            @(negedge clk); #1;
            imem_ready = imem_req;
            dmem_ready = 1'b0;
            #1;
            if (dmem_req) seen_mem++;
        end
        n_tests++;
        if (seen_mem !== 2) begin
            n_fail++; $display("[TB] FAIL mid_mem_reach: got %0d MEM cycles want 2", seen_mem);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (dmem_req !== 1'b0 || imem_req !== 1'b0 || retired !== '0 || state !== ST_FETCH) begin
            n_fail++; $display("[TB] FAIL mid_mem_reset: got dmem_req=%b imem_req=%b retired=%0d state=%0d want 0/0/0/%0d",
                dmem_req, imem_req, retired, state, ST_FETCH);
        end
        @(negedge clk);
        rst_n = 1'b1;
        imem_ready = 1'b0; dmem_ready = 1'b1;
        @(negedge clk); #1;
        n_tests++;
        if (imem_req !== 1'b1 || dmem_req !== 1'b0 || retired !== '0 || state !== ST_FETCH) begin
            n_fail++; $display("[TB] FAIL mid_mem_restart: got imem_req=%b dmem_req=%b retired=%0d state=%0d want 1/0/0/%0d",
                imem_req, dmem_req, retired, state, ST_FETCH);
        end
        dmem_ready = 1'b0;
        exp_cnt = 0;
        exec_instr(C_ALU, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        exp_cnt++;
        n_tests++;
        if (r_retired !== exp_cnt % CNT_MOD || r_cycles !== 3) begin
            n_fail++; $display("[TB] FAIL mid_mem_after: got retired=%0d cycles=%0d want %0d/3",
                r_retired, r_cycles, exp_cnt % CNT_MOD);
        end
    endtask

    task automatic test_halt();
        int cyc;
        bit fetched;
        cyc = 0; fetched = 1'b0;
        dec_hlt = 1'b1; dec_regwrite = 1'b1;
        dec_memtoreg = 1'b0; dec_memwrite = 1'b0; dec_branch = 1'b0; dec_jump = 1'b0;
        for (int c = 0; c < 20 && halted !== 1'b1; c++) begin
            @(negedge clk); #1;
            imem_ready = imem_req && !fetched;
            if (imem_req) fetched = 1'b1;
            #1;
            cyc++;
        end
        n_tests++;
        if (cyc !== 3 || halted !== 1'b1 || state !== ST_HALT) begin
            n_fail++; $display("[TB] FAIL halt_entry: got cycles=%0d halted=%b state=%0d want 3/1/%0d",
                cyc, halted, state, ST_HALT);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk); #1;
            imem_ready = 1'(c % 2);
            dmem_ready = 1'($urandom_range(1));
            #1;
            n_tests++;
            if ({imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we} !== 6'b0 || halted !== 1'b1 ||
                retired !== CNT_W'(exp_cnt % CNT_MOD)) begin
                n_fail++; $display("[TB] FAIL halt_hold%0d: got outs=%b halted=%b retired=%0d want 000000/1/%0d",
                    c, {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we}, halted, retired, exp_cnt % CNT_MOD);
            end
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_branch();
        test_load();
        test_store_jalr();
        test_random();
        test_reset_mid_mem();
        test_halt();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_fsm.md
CTRL_FSM -- requirements
Module: ctrl_fsm

Interface
REQ-001 Parameter: WORD, default 32, datapath word width.
REQ-002 Parameter: CNT_W, default 32, width of the retired-instruction counter.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 imem_ready  input  1  instruction memory has returned the word requested by imem_req.
REQ-006 dmem_ready  input  1  data memory has completed the access requested by dmem_req.
REQ-007 dec_regwrite, dec_memtoreg, dec_memwrite, dec_branch, dec_jump, dec_jumpsrc, dec_hlt  input  1 each  decoder control outputs for the current instruction register.
REQ-008 inv_br  input  1  branch-sense inversion from the decoder.
REQ-009 alu_lsb  input  1  bit 0 of the ALU result (compare outcome).
REQ-010 imem_req  output  1  instruction fetch request.
REQ-011 ir_we  output  1  load the instruction register.
REQ-012 dmem_req  output  1  data memory request.
REQ-013 dmem_we  output  1  data memory write qualifier; valid only while dmem_req=1.
REQ-014 rf_we  output  1  register file write enable.
REQ-015 wb_sel  output  1  0 = ALU result, 1 = memory data.
REQ-016 pc_we  output  1  PC update enable.
REQ-017 pc_src  output  2  0 = PC+4, 1 = PC+imm, 2 = rs1+imm.
REQ-018 halted  output  1  core stopped.
REQ-019 state  output  3  current FSM state, for debug.
REQ-020 retired  output  CNT_W  count of completed instructions.

Function
REQ-021 States: FETCH, DECODE, EXEC, MEM, WB, HALT; there is no other state.
REQ-022 FETCH: imem_req=1 until imem_ready is sampled high; in that cycle ir_we=1 and next state is DECODE; imem_req drops the following cycle.
REQ-023 DECODE: one cycle, all enables 0; next state is HALT if dec_hlt=1, else EXEC.
REQ-024 EXEC, branch: taken = alu_lsb XOR inv_br; pc_we=1; pc_src=1 if taken, else 0; next state FETCH.
REQ-025 EXEC, jump: rf_we=1, wb_sel=0, pc_we=1, pc_src=2 if dec_jumpsrc, else 1; next state FETCH.
REQ-026 EXEC, memtoreg or memwrite: no enables asserted; next state MEM.
REQ-027 EXEC, any other instruction: rf_we=dec_regwrite, wb_sel=0, pc_we=1, pc_src=0; next state FETCH.
REQ-028 MEM: dmem_req=1 and dmem_we=dec_memwrite, both held constant until dmem_ready is sampled high.
REQ-029 MEM exit on dmem_ready: load goes to WB; store asserts pc_we=1, pc_src=0 and goes to FETCH.
REQ-030 WB: rf_we=1, wb_sel=1, pc_we=1, pc_src=0; next state FETCH.
REQ-031 HALT: absorbing state; halted=1; all enables and requests 0; imem_ready and dmem_ready are ignored.
REQ-032 rf_we, pc_we and ir_we are each one-cycle pulses per instruction; never asserted twice for one instruction.
REQ-033 Latency: ALU op or branch takes 3 cycles plus fetch wait; load takes 5 cycles plus fetch and memory wait; store takes 4 cycles plus fetch and memory wait.
REQ-034 retired increments by 1 in every cycle with pc_we=1, wraps modulo 2^CNT_W, and holds in HALT.
REQ-035 imem_ready outside FETCH and dmem_ready outside MEM have no effect.
REQ-036 Outputs are decoded from state and registered inputs only; there is no combinational path from imem_ready or dmem_ready to a next request.

Reset
REQ-037 rst_n low asynchronously forces state=FETCH, retired=0, halted=0 and every enable and request output to 0.
REQ-038 Reset asserted mid-MEM or mid-FETCH abandons the access; the first request after reset is a fresh imem_req in FETCH.
REQ-039 On the first clock edge after rst_n rises, imem_req=1.

Structure
REQ-040 State encoding, pc_src codes and wb_sel codes live in shared package ctrl_pkg, alongside the existing ALU/opcode constants.
REQ-041 Single module; no sub-module is required; the next-state logic and the output decode are each one always_comb block.

Verification
REQ-042 ALU op (addi x1,x0,5 = 0x00500093) with imem_ready delayed 2 cycles: exactly one ir_we, then rf_we=1, wb_sel=0, pc_we=1, pc_src=0 in EXEC; retired 0->1.
REQ-043 Branch (blt): alu_lsb=1, inv_br=0 gives pc_src=1; alu_lsb=1, inv_br=1 gives pc_src=0; rf_we=0 in both cases.
REQ-044 Load with dmem_ready low for 3 MEM cycles: dmem_req held 4 cycles, dmem_we=0, then WB with rf_we=1, wb_sel=1; no rf_we in EXEC.
REQ-045 Store then jalr: store gives dmem_we=1 and PC+4 on ready; jalr gives pc_src=2 and rf_we=1; retired increments by 2.
REQ-046 ecall (0x00000073) with dec_hlt=1: DECODE goes to HALT, halted=1; imem_ready toggling for 10 cycles produces no outputs and retired is unchanged.
REQ-047 rst_n pulsed low during MEM: dmem_req drops immediately; after release, state=FETCH, retired=0, imem_req=1.
